// File: rtl/light_phase_scheduler.sv
// light_phase_scheduler
//   Two-direction traffic-light sequencer. Direction A drives led4, direction B
//   drives led5. Six phases run in a ring; each lasts a programmable number of
//   base ticks (T1 yellow, T2 green, T3 all-red). Holding start measures a
//   duration in ticks, shown live on led. Releasing start commits that duration
//   to the T register that sw selects.
//
// Ports
//   clk                     system clock
//   rst                     asynchronous, active-high reset
//   sw[1:0]                 slot select at release: 00 none, 01 T1, 10 T2, 11 T3
//   start                   asynchronous push button (synchronised internally)
//   led4_r/g/b, led5_r/g/b  direction A / B RGB drive (registered; b always 0)
//   led[DUR_W-1:0]          live measurement while start is held, else 0 (registered)
module light_phase_scheduler #(
  parameter int TICK_DIV = 125_000_000,
  parameter int DUR_W    = 4,
  parameter int DEF_T1   = 1,
  parameter int DEF_T2   = 5,
  parameter int DEF_T3   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       sw,
  input  logic             start,
  output logic             led4_r,
  output logic             led4_g,
  output logic             led4_b,
  output logic             led5_r,
  output logic             led5_g,
  output logic             led5_b,
  output logic [DUR_W-1:0] led
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [DUR_W-1:0] MEAS_MAX = '1;

  typedef enum logic [2:0] {
    ALLRED_A,
    A_GREEN,
    A_YELLOW,
    ALLRED_B,
    B_GREEN,
    B_YELLOW
  } phase_t;

  // ---------------------------------------------------------------------------
  // Base-tick prescaler
  // ---------------------------------------------------------------------------
  logic [PW-1:0] presc_reg;
  logic          tick;

  assign tick = (presc_reg == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_reg <= '0;
    end else if (tick) begin
      presc_reg <= '0;
    end else begin
      presc_reg <= presc_reg + PW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Duration registers and capture path
  // ---------------------------------------------------------------------------
  logic [DUR_W-1:0] t1_reg, t2_reg, t3_reg;
  logic             sync1_reg, sync2_reg, sync_d_reg;
  logic             rise, fall;
  logic [DUR_W-1:0] meas_reg, meas_next;
  logic [DUR_W-1:0] led_reg;

  assign rise = sync2_reg & ~sync_d_reg;
  assign fall = ~sync2_reg & sync_d_reg;

  // Rise has priority over a coincident tick so every measurement starts at 0.
  always_comb begin
    meas_next = meas_reg;
    if (rise) begin
      meas_next = '0;
    end else if (sync2_reg && tick && (meas_reg != MEAS_MAX)) begin
      meas_next = meas_reg + DUR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg  <= 1'b0;
      sync2_reg  <= 1'b0;
      sync_d_reg <= 1'b0;
      meas_reg   <= '0;
      led_reg    <= '0;
      t1_reg     <= DUR_W'(DEF_T1);
      t2_reg     <= DUR_W'(DEF_T2);
      t3_reg     <= DUR_W'(DEF_T3);
    end else begin
      sync1_reg  <= start;
      sync2_reg  <= sync1_reg;
      sync_d_reg <= sync2_reg;
      meas_reg   <= meas_next;
      led_reg    <= sync2_reg ? meas_next : '0;
      // A zero measurement would stall the phase ring, so it is never committed.
      if (fall && (meas_reg != '0)) begin
        case (sw)
          2'b01:   t1_reg <= meas_reg;
          2'b10:   t2_reg <= meas_reg;
          2'b11:   t3_reg <= meas_reg;
          default: ;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Phase FSM with registered LED decode
  // ---------------------------------------------------------------------------
  phase_t           state_reg, next_state;
  logic [DUR_W-1:0] cnt_reg, next_dur;
  logic             l4r_reg, l4g_reg, l5r_reg, l5g_reg;

  // Duration of the phase being entered comes from the T registers as they
  // stand before this edge, so a same-cycle commit is seen only by later loads.
  always_comb begin
    next_state = ALLRED_A;
    next_dur   = t3_reg;
    case (state_reg)
      ALLRED_A: begin next_state = A_GREEN;  next_dur = t2_reg; end
      A_GREEN:  begin next_state = A_YELLOW; next_dur = t1_reg; end
      A_YELLOW: begin next_state = ALLRED_B; next_dur = t3_reg; end
      ALLRED_B: begin next_state = B_GREEN;  next_dur = t2_reg; end
      B_GREEN:  begin next_state = B_YELLOW; next_dur = t1_reg; end
      B_YELLOW: begin next_state = ALLRED_A; next_dur = t3_reg; end
      default:  begin next_state = ALLRED_A; next_dur = t3_reg; end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ALLRED_A;
      cnt_reg   <= DUR_W'(DEF_T3);
      l4r_reg   <= 1'b0;
      l4g_reg   <= 1'b0;
      l5r_reg   <= 1'b0;
      l5g_reg   <= 1'b0;
    end else begin
      if (tick) begin
        // <= 1 rather than == 1 so a corrupted zero count still advances.
        if (cnt_reg <= DUR_W'(1)) begin
          state_reg <= next_state;
          cnt_reg   <= next_dur;
        end else begin
          cnt_reg <= cnt_reg - DUR_W'(1);
        end
      end
      // Decode from the current state; both directions default to red.
      l4r_reg <= 1'b1;
      l4g_reg <= 1'b0;
      l5r_reg <= 1'b1;
      l5g_reg <= 1'b0;
      case (state_reg)
        A_GREEN:  begin l4r_reg <= 1'b0; l4g_reg <= 1'b1; end
        A_YELLOW: begin l4g_reg <= 1'b1; end
        B_GREEN:  begin l5r_reg <= 1'b0; l5g_reg <= 1'b1; end
        B_YELLOW: begin l5g_reg <= 1'b1; end
        default:  ;
      endcase
    end
  end

  assign led4_r = l4r_reg;
  assign led4_g = l4g_reg;
  assign led4_b = 1'b0;
  assign led5_r = l5r_reg;
  assign led5_g = l5g_reg;
  assign led5_b = 1'b0;
  assign led    = led_reg;

endmodule

// File: tb/tb_light_phase_scheduler.sv
// tb_light_phase_scheduler
//   Self-checking bench for light_phase_scheduler at TICK_DIV=4. A behavioural
//   model (phase ring with remaining-cycle budgets, tick from the edge index,
//   start seen through a two-edge delay) predicts every output on every cycle.
//   Directed phase-length measurements, a capture table and randomized hold
//   sequences exercise commits, rejection of zero, saturation and resets.
module tb_light_phase_scheduler;

  localparam int TICK_DIV = 4;
  localparam int DUR_W    = 4;
  localparam int MAXM     = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] sw = 2'b00;
  logic       start = 1'b0;
  logic       led4_r, led4_g, led4_b, led5_r, led5_g, led5_b;
  logic [DUR_W-1:0] led;

  always #5 clk = ~clk;

  light_phase_scheduler #(
    .TICK_DIV(TICK_DIV),
    .DUR_W   (DUR_W),
    .DEF_T1  (1),
    .DEF_T2  (5),
    .DEF_T3  (1)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .sw    (sw),
    .start (start),
    .led4_r(led4_r),
    .led4_g(led4_g),
    .led4_b(led4_b),
    .led5_r(led5_r),
    .led5_g(led5_g),
    .led5_b(led5_b),
    .led   (led)
  );

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- reference model ----------------
  int         m_edge;      // edges since reset release
  int         m_phase;     // 0 ALLRED_A .. 5 B_YELLOW
  int         m_rem;       // clk cycles left in current phase
  int         m_meas;
  int         m_t[1:3];
  logic [2:0] m_hist;      // start at the last three edges, [0] newest
  logic [2:0] e4, e5;
  logic [3:0] eled;

  function automatic int phase_dur(int p);
    if (p == 1 || p == 4) return m_t[2];
    if (p == 2 || p == 5) return m_t[1];
    return m_t[3];
  endfunction

  function automatic logic [5:0] colours(int p);
    case (p)
      1:       return {3'b010, 3'b100};
      2:       return {3'b110, 3'b100};
      4:       return {3'b100, 3'b010};
      5:       return {3'b100, 3'b110};
      default: return {3'b100, 3'b100};
    endcase
  endfunction

  task automatic model_reset();
    m_edge  = 0;
    m_phase = 0;
    m_t[1]  = 1;
    m_t[2]  = 5;
    m_t[3]  = 1;
    m_rem   = m_t[3] * TICK_DIV;
    m_meas  = 0;
    m_hist  = '0;
    e4      = '0;
    e5      = '0;
    eled    = '0;
  endtask

  task automatic model_step();
    bit tick, h, hp;
    int old_meas;
    tick = (m_edge % TICK_DIV) == TICK_DIV - 1;
    h    = m_hist[1];
    hp   = m_hist[2];
    {e4, e5} = colours(m_phase);
    m_rem--;
    if (m_rem == 0) begin
      m_phase = (m_phase + 1) % 6;
      m_rem   = phase_dur(m_phase) * TICK_DIV;
    end
    old_meas = m_meas;
    if (h && !hp) m_meas = 0;
    else if (h && tick && m_meas < MAXM) m_meas++;
    eled = h ? 4'(m_meas) : 4'd0;
    if (hp && !h && sw != 2'b00 && old_meas != 0) m_t[int'(sw)] = old_meas;
    m_hist = {m_hist[1:0], start};
    m_edge++;
  endtask

  // ---------------- checking helpers ----------------
  task automatic check_outputs();
    logic [9:0] got, exp;
    got = {led4_r, led4_g, led4_b, led5_r, led5_g, led5_b, led};
    exp = {e4, e5, eled};
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL outputs t=%0t: got rgb4=%b rgb5=%b led=%0d, expected rgb4=%b rgb5=%b led=%0d",
               $time, got[9:7], got[6:4], got[3:0], exp[9:7], exp[6:4], exp[3:0]);
    end
  endtask

  task automatic check_int(string name, int got, int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst) model_step();
    @(negedge clk);
    check_outputs();
  endtask

  // Asserts reset between edges, checks the asynchronous clear, holds n cycles.
  task automatic do_reset(int n, bit drop_start);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_outputs();
    if (drop_start) start = 1'b0;
    repeat (n) cycle();
    rst = 1'b0;
  endtask

  function automatic bit in_phase(int which);
    case (which)
      1:       return led4_g && !led4_r;
      2:       return led4_g && led4_r;
      4:       return led5_g && !led5_r;
      5:       return led5_g && led5_r;
      default: return led4_r && !led4_g && led5_r && !led5_g;
    endcase
  endfunction

  // Length in cycles of a phase as seen on the LEDs. With fresh set, an
  // occurrence already in progress is skipped.
  task automatic phase_len(int which, bit fresh, output int len);
    int guard;
    guard = 0;
    len   = 0;
    if (fresh) while (in_phase(which) && guard < 1000) begin cycle(); guard++; end
    while (!in_phase(which) && guard < 1000) begin cycle(); guard++; end
    while (in_phase(which) && guard < 1000) begin len++; cycle(); guard++; end
  endtask

  task automatic check_len(string name, int which, bit fresh, int exp);
    int len;
    phase_len(which, fresh, len);
    check_int(name, len, exp);
    $display("phase %s: %0d cycles (expected %0d)", name, len, exp);
  endtask

  // Leaves the last edge index at 1 mod TICK_DIV, so a press raised now is
  // seen as a rise just after a tick.
  task automatic align();
    int guard;
    guard = 0;
    while ((m_edge % TICK_DIV) != 2 && guard < 16) begin cycle(); guard++; end
  endtask

  task automatic hold_start(int h, output int peak);
    start = 1'b1;
    peak  = 0;
    repeat (h) begin cycle(); if (int'(led) > peak) peak = int'(led); end
    start = 1'b0;
    repeat (5) begin cycle(); if (int'(led) > peak) peak = int'(led); end
  endtask

  task automatic wait_model(int phase, bit at_entry);
    int guard;
    guard = 0;
    while (!(m_phase == phase && (!at_entry || m_rem == phase_dur(phase) * TICK_DIV))
           && guard < 1000) begin
      cycle();
      guard++;
    end
    check_int("wait_for_phase", m_phase, phase);
  endtask

  task automatic default_sequence(string tag);
    check_len({tag, "_allred_a"}, 0, 1'b0, 4);
    check_len({tag, "_a_green"},  1, 1'b0, 20);
    check_len({tag, "_a_yellow"}, 2, 1'b0, 4);
    check_len({tag, "_allred_b"}, 0, 1'b0, 4);
    check_len({tag, "_b_green"},  4, 1'b0, 20);
    check_len({tag, "_b_yellow"}, 5, 1'b0, 4);
  endtask

  typedef struct {
    logic [1:0] sw;
    int         hold;
    int         exp_peak;
    int         which;
    int         exp_len;
  } vec_t;

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    int   peak;

    vecs[0] = '{sw: 2'b10, hold: 12, exp_peak: 3,  which: 4, exp_len: 12};
    vecs[1] = '{sw: 2'b01, hold: 2,  exp_peak: 0,  which: 2, exp_len: 4};
    vecs[2] = '{sw: 2'b11, hold: 80, exp_peak: 15, which: 0, exp_len: 60};
    vecs[3] = '{sw: 2'b00, hold: 12, exp_peak: 3,  which: 1, exp_len: 12};
    vecs[4] = '{sw: 2'b00, hold: 1,  exp_peak: 0,  which: 2, exp_len: 4};

    model_reset();
    #2;
    do_reset(3, 1'b1);
    $display("test reset: outputs cleared, releasing reset");

    default_sequence("t1");

    for (int i = 0; i < 5; i++) begin
      sw = vecs[i].sw;
      align();
      hold_start(vecs[i].hold, peak);
      check_int($sformatf("vec%0d_peak", i), peak, vecs[i].exp_peak);
      check_int($sformatf("vec%0d_led_idle", i), int'(led), 0);
      check_len($sformatf("vec%0d_len", i), vecs[i].which, 1'b1, vecs[i].exp_len);
      $display("vec %0d: sw=%b hold=%0d peak=%0d (expected %0d)",
               i, vecs[i].sw, vecs[i].hold, peak, vecs[i].exp_peak);
    end
    check_len("t2_a_green_again", 1, 1'b1, 12);

    // Commit T1 while A_YELLOW runs: 11-cycle press started at A_GREEN entry
    // spans three ticks and releases inside the yellow phase.
    wait_model(1, 1'b1);
    sw = 2'b01;
    start = 1'b1;
    repeat (11) cycle();
    start = 1'b0;
    check_len("t5_a_yellow_running", 2, 1'b0, 4);
    check_len("t5_b_yellow_new",     5, 1'b0, 12);
    check_len("t5_a_yellow_new",     2, 1'b0, 12);

    // Reset mid A_GREEN with start held: everything returns to defaults.
    wait_model(1, 1'b0);
    sw = 2'b10;
    start = 1'b1;
    repeat (6) cycle();
    do_reset(3, 1'b1);
    $display("test reset mid-phase: restarting default sequence");
    default_sequence("t6");

    // Start held through reset release: measurement begins two cycles later.
    sw = 2'b00;
    start = 1'b1;
    do_reset(2, 1'b0);
    repeat (10) cycle();
    start = 1'b0;
    repeat (6) cycle();
    check_len("t7_a_green_unchanged", 1, 1'b1, 20);
    $display("test start through reset: done");

    // Randomized presses, sw wiggles and occasional resets.
    for (int i = 0; i < 40; i++) begin
      int h, g;
      h = $urandom_range(1, 40);
      g = $urandom_range(1, 24);
      sw = 2'($urandom_range(0, 3));
      start = 1'b1;
      for (int k = 0; k < h; k++) begin
        if ($urandom_range(0, 7) == 0) sw = 2'($urandom_range(0, 3));
        cycle();
      end
      start = 1'b0;
      repeat (g) cycle();
      if ($urandom_range(0, 9) == 0) do_reset($urandom_range(1, 3), 1'($urandom_range(0, 1)));
      $display("random %0d: hold=%0d gap=%0d sw=%b", i, h, g, sw);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
